// File: rtl/rv32_exec_ctrl_if.sv
// Datapath bus of the RV32I execute/control core.
// The master side (fetch/regfile/immgen) drives instruction and operands;
// the slave side (the core) returns ALU result, PC values and control.
interface rv32_exec_ctrl_if;
    logic [31:0] iInitialPC;
    logic [31:0] iInstr;
    logic [31:0] iImm;
    logic [31:0] iRead1;
    logic [31:0] iRead2;
    logic [31:0] oPC;
    logic [31:0] oPC4;
    logic [31:0] oALUResult;
    logic        oZero;
    logic        oBranch;
    logic        oRegWrite;
    logic        oMemRead;
    logic        oMemWrite;
    logic [1:0]  oMem2Reg;
    logic [4:0]  oALUControl;
    logic [1:0]  oOrigPC;

    modport master (
        output iInitialPC, iInstr, iImm, iRead1, iRead2,
        input  oPC, oPC4, oALUResult, oZero, oBranch, oRegWrite,
               oMemRead, oMemWrite, oMem2Reg, oALUControl, oOrigPC
    );

    modport slave (
        input  iInitialPC, iInstr, iImm, iRead1, iRead2,
        output oPC, oPC4, oALUResult, oZero, oBranch, oRegWrite,
               oMemRead, oMemWrite, oMem2Reg, oALUControl, oOrigPC
    );
endinterface

// File: rtl/rv32_exec_ctrl.sv
// Single-cycle RV32I execute/control core: decode, ALU, branch compare,
// next-PC selection and the PC register.
// Optional macro RV32M_EN: implements MUL/DIV/REM codes 11..18; when it
// is undefined those codes decode normally but produce 0.
module rv32_exec_ctrl (
    input  logic             iCLK,
    input  logic             iRST,
    rv32_exec_ctrl_if.slave  bus
);
    localparam logic [4:0] ALU_AND  = 5'd0,  ALU_OR   = 5'd1,  ALU_XOR  = 5'd2;
    localparam logic [4:0] ALU_ADD  = 5'd3,  ALU_SUB  = 5'd4,  ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6,  ALU_SLL  = 5'd7,  ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9,  ALU_LUI  = 5'd10, ALU_MUL  = 5'd11;
    localparam logic [4:0] ALU_MULH = 5'd12, ALU_MULHSU = 5'd13, ALU_MULHU = 5'd14;
    localparam logic [4:0] ALU_DIV  = 5'd15, ALU_DIVU = 5'd16, ALU_REM  = 5'd17;
    localparam logic [4:0] ALU_REMU = 5'd18;

    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111, OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [31:0] pc_q, pc_d, pc4;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        unused_instr_bits;
    logic        reg_write, mem_read, mem_write, a_sel_pc, b_sel_reg, branch_taken;
    logic [1:0]  mem2reg, orig_pc;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [4:0]  shamt;

    assign opcode = bus.iInstr[6:0];
    assign funct3 = bus.iInstr[14:12];
    assign funct7 = bus.iInstr[31:25];
    // rd/rs1/rs2 fields are consumed by the register file, not here
    assign unused_instr_bits = ^{bus.iInstr[24:15], bus.iInstr[11:7]};

    // funct3 -> base integer ALU code; alt selects SUB / SRA
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Main decoder: opcode -> datapath control, unknown opcodes act as NOP
    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem2reg   = 2'b00;
        alu_ctrl  = ALU_AND;
        orig_pc   = 2'b00;
        a_sel_pc  = 1'b0;
        b_sel_reg = 1'b0;
        case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                b_sel_reg = 1'b1;
                if (funct7 == 7'b0000001) alu_ctrl = ALU_MUL + {2'b00, funct3};
                else                      alu_ctrl = base_alu(funct3, funct7[5]);
            end
            OPC_OPIMM: begin
                reg_write = 1'b1;
                // immediate ADDI has no SUB form; only the shift uses funct7
                alu_ctrl  = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OPC_LOAD:   begin alu_ctrl = ALU_ADD; mem_read = 1'b1; mem2reg = 2'b10; reg_write = 1'b1; end
            OPC_STORE:  begin alu_ctrl = ALU_ADD; mem_write = 1'b1; end
            OPC_BRANCH: begin alu_ctrl = ALU_SUB; orig_pc = 2'b01; b_sel_reg = 1'b1; end
            OPC_JAL:    begin orig_pc = 2'b10; mem2reg = 2'b01; reg_write = 1'b1; end
            OPC_JALR:   begin alu_ctrl = ALU_ADD; orig_pc = 2'b11; mem2reg = 2'b01; reg_write = 1'b1; end
            OPC_LUI:    begin alu_ctrl = ALU_LUI; reg_write = 1'b1; end
            OPC_AUIPC:  begin alu_ctrl = ALU_ADD; a_sel_pc = 1'b1; reg_write = 1'b1; end
            default: ;
        endcase
    end

    assign alu_a = a_sel_pc  ? pc_q       : bus.iRead1;
    assign alu_b = b_sel_reg ? bus.iRead2 : bus.iImm;
    assign shamt = alu_b[4:0];

`ifdef RV32M_EN
    logic [63:0] prod_ss, prod_su, prod_uu;
    logic        div_zero, div_ovf;
    logic [31:0] sdiv_b, udiv_b, quot_s, rem_s, quot_u, rem_u;

    // Sign-extended 64-bit multiplies; low 64 bits equal the exact product
    assign prod_ss = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
    assign prod_su = {{32{alu_a[31]}}, alu_a} * {32'd0, alu_b};
    assign prod_uu = {32'd0, alu_a} * {32'd0, alu_b};

    // Divisor forced to 1 for /0 and MIN/-1: the latter then yields MIN
    // quotient and 0 remainder directly, the former is overridden below
    assign div_zero = (alu_b == 32'd0);
    assign div_ovf  = (alu_a == 32'h8000_0000) && (alu_b == 32'hFFFF_FFFF);
    assign sdiv_b   = (div_zero || div_ovf) ? 32'd1 : alu_b;
    assign udiv_b   = div_zero ? 32'd1 : alu_b;
    assign quot_s   = $signed(alu_a) / $signed(sdiv_b);
    assign rem_s    = $signed(alu_a) % $signed(sdiv_b);
    assign quot_u   = alu_a / udiv_b;
    assign rem_u    = alu_a % udiv_b;
`endif

    // ALU: one result per operation code, undefined codes give 0
    always_comb begin
        alu_res = 32'd0;
        case (alu_ctrl)
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
            ALU_SLL:  alu_res = alu_a << shamt;
            ALU_SRL:  alu_res = alu_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
            ALU_LUI:  alu_res = alu_b;
`ifdef RV32M_EN
            ALU_MUL:    alu_res = prod_ss[31:0];
            ALU_MULH:   alu_res = prod_ss[63:32];
            ALU_MULHSU: alu_res = prod_su[63:32];
            ALU_MULHU:  alu_res = prod_uu[63:32];
            ALU_DIV:    alu_res = div_zero ? 32'hFFFF_FFFF : quot_s;
            ALU_DIVU:   alu_res = div_zero ? 32'hFFFF_FFFF : quot_u;
            ALU_REM:    alu_res = div_zero ? alu_a : rem_s;
            ALU_REMU:   alu_res = div_zero ? alu_a : rem_u;
`endif
            default:  alu_res = 32'd0;
        endcase
    end

    // Branch condition from funct3, always on the raw rs1/rs2 values
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (bus.iRead1 == bus.iRead2);
            3'b001:  branch_taken = (bus.iRead1 != bus.iRead2);
            3'b100:  branch_taken = ($signed(bus.iRead1) <  $signed(bus.iRead2));
            3'b101:  branch_taken = ($signed(bus.iRead1) >= $signed(bus.iRead2));
            3'b110:  branch_taken = (bus.iRead1 <  bus.iRead2);
            3'b111:  branch_taken = (bus.iRead1 >= bus.iRead2);
            default: branch_taken = 1'b0;
        endcase
    end

    assign pc4 = pc_q + 32'd4;

    // Next-PC mux; JALR target has bit 0 cleared
    always_comb begin
        pc_d = pc4;
        case (orig_pc)
            2'b01:   pc_d = branch_taken ? (pc_q + bus.iImm) : pc4;
            2'b10:   pc_d = pc_q + bus.iImm;
            2'b11:   pc_d = (bus.iRead1 + bus.iImm) & 32'hFFFF_FFFE;
            default: pc_d = pc4;
        endcase
    end

    // PC register; reset reloads the initial PC regardless of the instruction
    always_ff @(posedge iCLK) begin
        if (iRST) pc_q <= bus.iInitialPC;
        else      pc_q <= pc_d;
    end

    assign bus.oPC         = pc_q;
    assign bus.oPC4        = pc4;
    assign bus.oALUResult  = alu_res;
    assign bus.oZero       = (alu_res == 32'd0);
    assign bus.oBranch     = branch_taken;
    assign bus.oRegWrite   = reg_write;
    assign bus.oMemRead    = mem_read;
    assign bus.oMemWrite   = mem_write;
    assign bus.oMem2Reg    = mem2reg;
    assign bus.oALUControl = alu_ctrl;
    assign bus.oOrigPC     = orig_pc;
endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Testbench for rv32_exec_ctrl: directed cases followed by random
// instructions compared against an instruction-level reference model.
module tb_rv32_exec_ctrl;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] model_pc;

    rv32_exec_ctrl_if bus();

    rv32_exec_ctrl dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im);
        bus.iInstr = ins;
        bus.iRead1 = r1;
        bus.iRead2 = r2;
        bus.iImm   = im;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst = 1'b1;
        bus.iInitialPC = pc0;
        drive(32'h0000_0013, 32'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        chk("reset_pc", bus.oPC, pc0);
        model_pc = pc0;
    endtask

    // Reference ALU: arithmetic on 64-bit integers, truncated to 32 bits
    function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          r  = 0;
        case (code)
            0:  r = longint'(ua & ub);
            1:  r = longint'(ua | ub);
            2:  r = longint'(ua ^ ub);
            3:  r = sa + sb;
            4:  r = sa - sb;
            5:  r = (sa < sb) ? 1 : 0;
            6:  r = (ua < ub) ? 1 : 0;
            7:  r = longint'(ua << b[4:0]);
            8:  r = longint'(ua >> b[4:0]);
            9:  r = sa >>> b[4:0];
            10: r = sb;
`ifdef RV32M_EN
            11: r = sa * sb;
            12: r = (sa * sb) >>> 32;
            13: r = (sa * longint'(ub)) >>> 32;
            14: r = longint'((ua * ub) >> 32);
            15: r = (b == 0) ? 64'hFFFF_FFFF : sa / sb;
            16: r = (b == 0) ? 64'hFFFF_FFFF : longint'(ua / ub);
            17: r = (b == 0) ? sa : sa % sb;
            18: r = (b == 0) ? sa : longint'(ua % ub);
`endif
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // RISC-V funct3 meaning for integer register/immediate ops
    function automatic int f3_code(input logic [2:0] f3, input logic alt);
        int tbl [8] = '{3, 7, 5, 6, 2, 8, 1, 0};
        if (alt && f3 == 3'd0) return 4;
        if (alt && f3 == 3'd5) return 9;
        return tbl[f3];
    endfunction

    task automatic ref_model(input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                             output logic [31:0] res, output logic rw, output logic mr,
                             output logic mw, output logic [1:0] m2r, output logic [4:0] ctl,
                             output logic [1:0] osel, output logic br, output logic [31:0] npc);
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] a, b;
        int code = 0;
        rw = 0; mr = 0; mw = 0; m2r = 0; osel = 0;
        case (opc)
            7'h33: begin rw = 1; code = (f7 == 7'h01) ? 11 + int'(f3) : f3_code(f3, f7[5]); end
            7'h13: begin rw = 1; code = f3_code(f3, (f3 == 3'd5) && f7[5]); end
            7'h03: begin code = 3; mr = 1; m2r = 2; rw = 1; end
            7'h23: begin code = 3; mw = 1; end
            7'h63: begin code = 4; osel = 1; end
            7'h6F: begin osel = 2; m2r = 1; rw = 1; end
            7'h67: begin code = 3; osel = 3; m2r = 1; rw = 1; end
            7'h37: begin code = 10; rw = 1; end
            7'h17: begin code = 3; rw = 1; end
            default: ;
        endcase
        a   = (opc == 7'h17) ? pc : r1;
        b   = (opc == 7'h33 || opc == 7'h63) ? r2 : im;
        ctl = 5'(code);
        res = ref_alu(code, a, b);
        case (f3)
            3'd0: br = (r1 == r2);
            3'd1: br = (r1 != r2);
            3'd4: br = ($signed(r1) <  $signed(r2));
            3'd5: br = ($signed(r1) >= $signed(r2));
            3'd6: br = (r1 <  r2);
            3'd7: br = (r1 >= r2);
            default: br = 0;
        endcase
        case (osel)
            2'd1:    npc = br ? pc + im : pc + 32'd4;
            2'd2:    npc = pc + im;
            2'd3:    npc = (r1 + im) & ~32'd1;
            default: npc = pc + 32'd4;
        endcase
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] im, input logic rst_v, input logic [31:0] init_v);
        logic [31:0] e_res, e_npc;
        logic        e_rw, e_mr, e_mw, e_br;
        logic [1:0]  e_m2r, e_osel;
        logic [4:0]  e_ctl;
        drive(ins, r1, r2, im);
        rst = rst_v;
        bus.iInitialPC = init_v;
        ref_model(ins, model_pc, r1, r2, im, e_res, e_rw, e_mr, e_mw, e_m2r, e_ctl, e_osel, e_br, e_npc);
        #1;
        chk("pc_cur",   bus.oPC,                 model_pc);
        chk("pc4",      bus.oPC4,                model_pc + 32'd4);
        chk("alu_res",  bus.oALUResult,          e_res);
        chk("zero",     {31'd0, bus.oZero},      {31'd0, e_res == 32'd0});
        chk("branch",   {31'd0, bus.oBranch},    {31'd0, e_br});
        chk("regwrite", {31'd0, bus.oRegWrite},  {31'd0, e_rw});
        chk("memread",  {31'd0, bus.oMemRead},   {31'd0, e_mr});
        chk("memwrite", {31'd0, bus.oMemWrite},  {31'd0, e_mw});
        chk("mem2reg",  {30'd0, bus.oMem2Reg},   {30'd0, e_m2r});
        chk("aluctl",   {27'd0, bus.oALUControl}, {27'd0, e_ctl});
        chk("origpc",   {30'd0, bus.oOrigPC},    {30'd0, e_osel});
        tick();
        model_pc = rst_v ? init_v : e_npc;
        chk("pc_next", bus.oPC, model_pc);
        rst = 1'b0;
        $display("txn ins=%08h rs1=%08h rs2=%08h imm=%08h rst=%0d res=%08h pc=%08h",
                 ins, r1, r2, im, rst_v, e_res, model_pc);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        logic [31:0] exp_div, exp_mulhu;
        rst = 1'b0;
        bus.iInitialPC = 32'd0;
        drive(32'h0000_0013, 32'd0, 32'd0, 32'd0);

        // Reset and sequential fetch
        do_reset(32'h0040_0000);
        tick(); chk("nop_pc1", bus.oPC, 32'h0040_0004);
        tick(); chk("nop_pc2", bus.oPC, 32'h0040_0008);
        $display("txn reset/nop stream pc=%08h", bus.oPC);

        // ADD wrapping to zero
        drive(32'h0000_0033, 32'd5, 32'hFFFF_FFFB, 32'd0); #1;
        chk("add_res", bus.oALUResult, 32'd0);
        chk("add_zero", {31'd0, bus.oZero}, 32'd1);
        chk("add_rw", {31'd0, bus.oRegWrite}, 32'd1);
        tick();
        $display("txn add res=%08h", 32'd0);

        // SRA
        drive(32'h4000_5033, 32'h8000_0000, 32'd4, 32'd0); #1;
        chk("sra_res", bus.oALUResult, 32'hF800_0000);
        tick();
        $display("txn sra res=%08h", 32'hF800_0000);

        // BLT taken / BLTU not taken
        do_reset(32'h100);
        drive(32'h0000_4063, 32'hFFFF_FFFF, 32'd1, 32'd16); #1;
        chk("blt_br", {31'd0, bus.oBranch}, 32'd1);
        tick(); chk("blt_pc", bus.oPC, 32'h110);
        $display("txn blt pc=%08h", 32'h110);
        do_reset(32'h100);
        drive(32'h0000_6063, 32'hFFFF_FFFF, 32'd1, 32'd16); #1;
        chk("bltu_br", {31'd0, bus.oBranch}, 32'd0);
        tick(); chk("bltu_pc", bus.oPC, 32'h104);
        $display("txn bltu pc=%08h", 32'h104);

        // JALR
        do_reset(32'h200);
        drive(32'h0000_0067, 32'h1003, 32'd0, 32'd4); #1;
        chk("jalr_pc4", bus.oPC4, 32'h204);
        chk("jalr_m2r", {30'd0, bus.oMem2Reg}, 32'd1);
        tick(); chk("jalr_pc", bus.oPC, 32'h1006);
        $display("txn jalr pc=%08h", 32'h1006);

        // LW / SW address and enables
        drive(32'h0000_2003, 32'h1001_0000, 32'd0, 32'd8); #1;
        chk("lw_addr", bus.oALUResult, 32'h1001_0008);
        chk("lw_mr", {31'd0, bus.oMemRead}, 32'd1);
        tick();
        drive(32'h0000_2023, 32'h1001_0000, 32'd0, 32'd8); #1;
        chk("sw_addr", bus.oALUResult, 32'h1001_0008);
        chk("sw_mw", {31'd0, bus.oMemWrite}, 32'd1);
        chk("sw_rw", {31'd0, bus.oRegWrite}, 32'd0);
        tick();
        $display("txn lw/sw addr=%08h", 32'h1001_0008);

        // M extension corner cases
`ifdef RV32M_EN
        exp_div = 32'hFFFF_FFFF; exp_mulhu = 32'hFFFF_FFFE;
`else
        exp_div = 32'd0; exp_mulhu = 32'd0;
`endif
        drive(32'h0200_4033, 32'd7, 32'd0, 32'd0); #1;
        chk("div_by0", bus.oALUResult, exp_div);
        chk("div_ctl", {27'd0, bus.oALUControl}, 32'd15);
        tick();
        drive(32'h0200_3033, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0); #1;
        chk("mulhu", bus.oALUResult, exp_mulhu);
        tick();
        $display("txn m-ext div=%08h mulhu=%08h", exp_div, exp_mulhu);

        // Random instructions against the reference model
        do_reset($urandom() & 32'hFFFF_FFFC);
        for (int i = 0; i < 400; i++) begin
            logic [6:0]  opc = opcs[$urandom_range(0, 9)];
            logic [6:0]  f7;
            logic [31:0] ins, r1, r2;
            logic        rv;
            if (opc == 7'h00) opc = 7'($urandom());
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom());
            endcase
            ins = {f7, 10'($urandom()), 3'($urandom()), 5'($urandom()), opc};
            r1  = pick_val();
            r2  = ($urandom_range(0, 5) == 0) ? r1 : pick_val();
            rv  = ($urandom_range(0, 31) == 0);
            run_instr(ins, r1, r2, pick_val(), rv, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
